// File: rtl/tdm16_demux.sv
// tdm16_demux: walks the select lines of an upstream 16:1 selector and
// rebuilds each 16-sample frame into a parallel word with framing checks.
module tdm16_demux #(
    parameter int INVERT_IN = 1,
    parameter int CHANNELS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_n,
    input  logic        sync,
    input  logic        din,
    output logic [3:0]  sel,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        frame_err
);

    generate
        if (CHANNELS != 16) begin : g_bad_channels
            $error("tdm16_demux supports CHANNELS == 16 only");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic INV = (INVERT_IN != 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [14:0] r_shd;
    logic [15:0] r_dout;
    logic        r_dout_valid;
    logic        r_frame_err;

    logic        w_b;
    logic        w_active;
    logic        w_last;
    logic        w_mid;

    assign w_b      = din ^ INV;
    assign w_active = ~en_n;
    assign w_last   = (r_cnt == 4'd15);
    assign w_mid    = (r_cnt != 4'd0);

    // Single-process FSM; every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_shd        <= 15'd0;
            r_dout       <= 16'd0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_active) begin
                case (r_state)
                    S_IDLE: begin
                        if (sync) begin
                            r_shd[0] <= w_b;
                            r_cnt    <= 4'd1;
                            r_state  <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (sync) begin
                            // A sync anywhere but slot 0 restarts the frame here.
                            r_frame_err <= w_mid;
                            r_shd[0]    <= w_b;
                            r_cnt       <= 4'd1;
                        end else if (w_last) begin
                            r_dout       <= {w_b, r_shd};
                            r_dout_valid <= 1'b1;
                            r_cnt        <= 4'd0;
                        end else begin
                            r_shd[r_cnt] <= w_b;
                            r_cnt        <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign sel        = r_cnt;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_tdm16_demux.sv
// tb_tdm16_demux: directed and random frames against a queue-based
// frame model, with both polarities of INVERT_IN instantiated side by side.
module tb_tdm16_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_n = 1'b1;
    logic        sync = 1'b0;
    logic        din = 1'b0;

    logic [3:0]  sel0, sel1;
    logic [15:0] dout0, dout1;
    logic        v0, v1, e0, e1;

    tdm16_demux #(.INVERT_IN(0), .CHANNELS(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .sync(sync), .din(din),
        .sel(sel0), .dout(dout0), .dout_valid(v0), .frame_err(e0)
    );

    tdm16_demux #(.INVERT_IN(1), .CHANNELS(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .sync(sync), .din(din),
        .sel(sel1), .dout(dout1), .dout_valid(v1), .frame_err(e1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_run;
    bit          m_q[$];
    logic [3:0]  exp_sel;
    logic [15:0] exp_d0, exp_d1;
    logic        exp_v, exp_e;
    int          obs_v = 0;
    int          obs_e = 0;

    task automatic model_reset();
        m_run = 1'b0;
        m_q.delete();
        exp_sel = 4'd0;
        exp_d0 = 16'd0;
        exp_d1 = 16'd0;
        exp_v = 1'b0;
        exp_e = 1'b0;
    endtask

    // Drive one cycle from a negedge, predict, then land on the next negedge.
    task automatic cyc(input logic e, input logic s, input logic d);
        logic [15:0] w;
        en_n = e;
        sync = s;
        din = d;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (!e) begin
            if (s) begin
                exp_e = m_run && (m_q.size() != 0);
                m_q.delete();
                m_q.push_back(d);
                m_run = 1'b1;
            end else if (m_run) begin
                m_q.push_back(d);
                if (m_q.size() == 16) begin
                    for (int i = 0; i < 16; i++) w[i] = m_q[i];
                    exp_d0 = w;
                    exp_d1 = ~w;
                    exp_v = 1'b1;
                    m_q.delete();
                end
            end
        end
        exp_sel = 4'(m_q.size());
        @(posedge clk);
        @(negedge clk);
        if (v0) obs_v++;
        if (e0) obs_e++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_n = 1'b0;
        sync = 1'b1;
        din = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sel0 !== 4'd0) begin errors++; $display("FAIL reset_sel0 got %0h want 0", sel0); end
        checks++; if (dout0 !== 16'd0) begin errors++; $display("FAIL reset_dout0 got %0h want 0", dout0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b want 0", v0); end
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b want 0", e0); end
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL reset_sel1 got %0h want 0", sel1); end
        checks++; if (dout1 !== 16'd0) begin errors++; $display("FAIL reset_dout1 got %0h want 0", dout1); end
        checks++; if (v1 !== 1'b0 || e1 !== 1'b0) begin errors++; $display("FAIL reset_flags1 got %b%b want 00", v1, e1); end
        en_n = 1'b1;
        sync = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic [15:0] w;
        int vt;
        w = 16'hA5C3;
        vt = -1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (sel0 !== 4'(i)) begin errors++; $display("FAIL basic_sel got %0d want %0d", sel0, i); end
            cyc(1'b0, i == 0, w[i]);
            if (v0 && vt < 0) vt = i + 1;
        end
        checks++; if (vt !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", vt); end
        checks++; if (dout0 !== 16'hA5C3) begin errors++; $display("FAIL basic_dout0 got %0h want a5c3", dout0); end
        checks++; if (dout1 !== 16'h5A3C) begin errors++; $display("FAIL basic_dout1 got %0h want 5a3c", dout1); end
        checks++; if (obs_e !== 0) begin errors++; $display("FAIL basic_err got %0d want 0", obs_e); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", v0); end
        checks++; if (dout0 !== 16'hA5C3) begin errors++; $display("FAIL basic_hold got %0h want a5c3", dout0); end
    endtask

    task automatic test_invert();
        for (int i = 0; i < 16; i++) cyc(1'b0, i == 0, 1'b0);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL inv_valid got %b want 1", v1); end
        checks++; if (dout1 !== 16'hFFFF) begin errors++; $display("FAIL inv_dout1 got %0h want ffff", dout1); end
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL inv_dout0 got %0h want 0", dout0); end
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL inv_err got %b want 0", e1); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [2];
        logic [15:0] got [2];
        int t [2];
        int k;
        int n;
        words[0] = 16'h1234;
        words[1] = 16'hFEDC;
        k = 0;
        n = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                cyc(1'b0, f == 0 && i == 0, words[f][i]);
                n++;
                if (v0) begin
                    if (k < 2) begin
                        got[k] = dout0;
                        t[k] = n;
                    end
                    k++;
                end
            end
        end
        checks++; if (k !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", k); end
        if (k == 2) begin
            checks++; if (t[1] - t[0] !== 16) begin errors++; $display("FAIL b2b_gap got %0d want 16", t[1] - t[0]); end
            checks++; if (got[0] !== 16'h1234) begin errors++; $display("FAIL b2b_first got %0h want 1234", got[0]); end
            checks++; if (got[1] !== 16'hFEDC) begin errors++; $display("FAIL b2b_second got %0h want fedc", got[1]); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        int t;
        int vt;
        int e_start;
        w = 16'($urandom);
        t = 0;
        vt = -1;
        e_start = obs_e;
        for (int ch = 0; ch < 16; ch++) begin
            if (ch == 6 || ch == 15) begin
                repeat ((ch == 6) ? 3 : 1) begin
                    cyc(1'b1, 1'b1, 1'($urandom));
                    t++;
                    checks++;
                    if (sel0 !== 4'(ch)) begin errors++; $display("FAIL stall_sel got %0d want %0d", sel0, ch); end
                end
            end
            cyc(1'b0, ch == 0, w[ch]);
            t++;
            if (v0 && vt < 0) vt = t;
        end
        checks++; if (vt !== 20) begin errors++; $display("FAIL stall_latency got %0d want 20", vt); end
        checks++; if (dout0 !== w) begin errors++; $display("FAIL stall_dout got %0h want %0h", dout0, w); end
        checks++; if (obs_e !== e_start) begin errors++; $display("FAIL stall_err got %0d want %0d", obs_e, e_start); end
    endtask

    task automatic test_frame_err();
        logic [15:0] a, b, prior;
        int v_start, e_start, vt;
        a = 16'($urandom);
        b = 16'($urandom);
        prior = dout0;
        v_start = obs_v;
        e_start = obs_e;
        vt = -1;
        cyc(1'b0, 1'b1, a[0]);
        for (int i = 1; i < 9; i++) cyc(1'b0, 1'b0, a[i]);
        checks++; if (sel0 !== 4'd9) begin errors++; $display("FAIL ferr_sel got %0d want 9", sel0); end
        cyc(1'b0, 1'b1, b[0]);
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b want 1", e0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", v0); end
        checks++; if (dout0 !== prior) begin errors++; $display("FAIL ferr_keep got %0h want %0h", dout0, prior); end
        checks++; if (sel0 !== 4'd1) begin errors++; $display("FAIL ferr_restart got %0d want 1", sel0); end
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b0, b[i]);
            if (v0 && vt < 0) vt = i + 1;
        end
        checks++; if (vt !== 16) begin errors++; $display("FAIL ferr_latency got %0d want 16", vt); end
        checks++; if (obs_e - e_start !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", obs_e - e_start); end
        checks++; if (obs_v - v_start !== 1) begin errors++; $display("FAIL ferr_vcount got %0d want 1", obs_v - v_start); end
        checks++; if (dout0 !== b) begin errors++; $display("FAIL ferr_dout got %0h want %0h", dout0, b); end
        checks++; if (dout1 !== ~b) begin errors++; $display("FAIL ferr_dout1 got %0h want %0h", dout1, ~b); end
    endtask

    task automatic test_async_reset();
        logic [15:0] w;
        int v_start;
        w = (16'($urandom) | 16'h0001) & 16'hFFFD;
        for (int i = 0; i < 16; i++) cyc(1'b0, i == 0, w[i]);
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 7; i++) cyc(1'b0, 1'b0, 1'($urandom));
        checks++; if (sel0 !== 4'd7) begin errors++; $display("FAIL arst_pre_sel got %0d want 7", sel0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sel0 !== 4'd0 || sel1 !== 4'd0) begin errors++; $display("FAIL arst_sel got %0d/%0d want 0", sel0, sel1); end
        checks++; if (dout0 !== 16'd0) begin errors++; $display("FAIL arst_dout0 got %0h want 0", dout0); end
        checks++; if (dout1 !== 16'd0) begin errors++; $display("FAIL arst_dout1 got %0h want 0", dout1); end
        checks++; if ({v0, e0, v1, e1} !== 4'b0) begin errors++; $display("FAIL arst_flags got %b want 0000", {v0, e0, v1, e1}); end
        #1 rst_n = 1'b1;
        model_reset();
        v_start = obs_v;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom));
            checks++;
            if (sel0 !== 4'd0) begin errors++; $display("FAIL arst_idle_sel got %0d want 0", sel0); end
        end
        checks++; if (obs_v !== v_start) begin errors++; $display("FAIL arst_novalid got %0d want %0d", obs_v, v_start); end
        for (int i = 0; i < 16; i++) cyc(1'b0, i == 0, w[i]);
        checks++; if (v0 !== 1'b1 || dout0 !== w) begin errors++; $display("FAIL arst_recover got %b/%0h want 1/%0h", v0, dout0, w); end
    endtask

    task automatic test_random();
        logic e, s, d;
        for (int n = 0; n < 800; n++) begin
            e = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 24) == 0);
            d = 1'($urandom);
            cyc(e, s, d);
            checks++; if (sel0 !== exp_sel || sel1 !== exp_sel) begin errors++; $display("FAIL rnd_sel n=%0d got %0d/%0d want %0d", n, sel0, sel1, exp_sel); end
            checks++; if (v0 !== exp_v || v1 !== exp_v) begin errors++; $display("FAIL rnd_valid n=%0d got %b/%b want %b", n, v0, v1, exp_v); end
            checks++; if (e0 !== exp_e || e1 !== exp_e) begin errors++; $display("FAIL rnd_err n=%0d got %b/%b want %b", n, e0, e1, exp_e); end
            checks++; if (dout0 !== exp_d0) begin errors++; $display("FAIL rnd_dout0 n=%0d got %0h want %0h", n, dout0, exp_d0); end
            checks++; if (dout1 !== exp_d1) begin errors++; $display("FAIL rnd_dout1 n=%0d got %0h want %0h", n, dout1, exp_d1); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_invert();
        cyc(1'b1, 1'b0, 1'b0);
        test_back_to_back();
        test_stall();
        test_frame_err();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm16_demux.md
# tdm16_demux

Sequential receive-side counterpart to the team's 16:1 selector: it drives the 4-bit channel select toward an upstream 16:1 selector and samples the selector's single-bit output one channel per enabled cycle. It reassembles the 16 samples into a parallel word and flags framing errors. It sits between the selector's output pin and the parallel consumer logic.

## Interface

Parameters:
- INVERT_IN, default 1: when 1, `din` is inverted before capture. This undoes the selector's inverting output stage.
- CHANNELS, default 16: fixed at 16. Any other value is a synthesis error.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en_n  input  1  active-low sample enable. When high, the block stalls.
- sync  input  1  frame marker. High in the cycle whose `din` carries channel 0.
- din  input  1  serial sample from the selector output.
- sel  output  4  channel the block samples in the current cycle. Drives the selector's select inputs.
- dout  output  16  last complete frame. Bit i = channel i (post-inversion).
- dout_valid  output  1  one-cycle pulse when `dout` updates.
- frame_err  output  1  one-cycle pulse on a mid-frame `sync`.

## Operation

- Internal state: `state` (IDLE, RUN), 4-bit counter `cnt`, 15-bit shadow register `shd`.
- Sampled bit `b` = din XOR INVERT_IN.
- `sel` = `cnt`, taken directly from the register with no combinational path from inputs. In IDLE, `cnt` = 0.
- A cycle is "active" when en_n = 0.
- Inactive cycle:
  - all state holds;
  - dout_valid = 0 and frame_err = 0 on the next edge.

IDLE:
- Active with sync = 1: `shd[0]` <= b, `cnt` <= 1, go to RUN.
- Active with sync = 0: the sample is discarded and the block stays in IDLE.

RUN, active, sync = 0:
- `cnt` in 1..14: `shd[cnt]` <= b, `cnt` <= `cnt`+1.
- `cnt` = 15:
  - `dout` <= {b, `shd[14:0]`};
  - dout_valid <= 1;
  - `cnt` <= 0 (wraps);
  - stays in RUN.
- `cnt` = 0: `shd[0]` <= b, `cnt` <= 1. Back-to-back frames need no `sync`.

RUN, active, sync = 1:
- `cnt` = 0: normal frame start, no error.
- `cnt` ≠ 0:
  - frame_err <= 1;
  - the partial frame is discarded and `dout` is unchanged;
  - `shd[0]` <= b, `cnt` <= 1. The current bit becomes channel 0 of a new frame.
- `cnt` = 15 with sync = 1 counts as an error. The frame does not complete and dout_valid stays 0.

Other rules:
- Bits of `shd` that are not written keep stale values. This is harmless because every completed frame rewrites bits 0..14.
- dout_valid and frame_err are mutually exclusive by construction.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0, shd = 0;
  - sel = 0, dout = 0, dout_valid = 0, frame_err = 0.
- Reset asserted mid-frame aborts the frame immediately. After release, the block waits in IDLE for `sync`.
- Latency: `dout` and dout_valid become visible one clock after the edge on which channel 15 is sampled. This is 16 active cycles after the `sync` cycle, plus any stall cycles.
- `sel` changes only on clock edges. The selector has one full cycle for propagation before `din` is sampled.
- Throughput: one frame per 16 active cycles, with no dead cycle between frames.
- Stall behaviour:
  - en_n high holds `sel`, so the selector output stays on the same channel;
  - no sample is lost or duplicated;
  - `sync` is ignored while en_n is high.
- Simultaneous completion and stall cannot occur: completion requires en_n = 0.

## Test plan

1. Reset, then sync on cycle 0 with din stream 0xA5C3 (bit 0 first), INVERT_IN = 0, en_n = 0 throughout. Required: sel counts 0..15; dout = 0xA5C3 with dout_valid high exactly one cycle, 16 cycles after sync; frame_err = 0.
2. INVERT_IN = 1, raw din all-zero for one synced frame. Required: dout = 0xFFFF.
3. Two back-to-back frames 0x1234 then 0xFEDC, sync only on the first. Required: two dout_valid pulses 16 cycles apart, dout = 0x1234 then 0xFEDC.
4. Stalls: en_n high for 3 cycles after channel 5, and for 1 cycle before channel 15. Required: sel holds at 6 and 15 during the stalls; dout correct; valid arrives 20 cycles after sync.
5. Sync re-asserted at cnt = 9 during a frame. Required: frame_err pulses once; no dout_valid for the aborted frame; dout keeps its prior value; a new frame captured from that cycle completes 16 active cycles later.
6. rst_n pulsed low asynchronously (mid-cycle) at cnt = 7. Required: all outputs and sel are 0 immediately; sync-less data afterwards yields no dout_valid until the next sync.
